// File: rtl/muldiv_16b_if.sv
// Request/response bundle between the core and the multiply/divide unit.
// The response side feeds the register-file write port directly.
interface muldiv_16b_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [ADDR_W-1:0] rd_in;
    logic              busy;
    logic              done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  result;

    modport master (
        output start, op, a, b, rd_in,
        input  busy, done, wr_en, wr_addr, result
    );

    modport slave (
        input  start, op, a, b, rd_in,
        output busy, done, wr_en, wr_addr, result
    );
endinterface

// File: rtl/muldiv_16b.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider.
// Fixed latency of WIDTH iterations; the result is written straight to the register file.
module muldiv_16b #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_16b_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, next_state;
    logic [1:0]          op_q;
    logic [WIDTH-1:0]    opa, opb;
    logic [ADDR_W-1:0]   rd_q;
    logic [CNT_W-1:0]    cnt;
    logic [2*WIDTH-1:0]  prod, prod_next;
    logic [WIDTH-1:0]    rem, rem_next;
    logic [WIDTH-1:0]    quot, quot_next;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_shift;
    logic                div_ge;
    logic                busy_q, done_q;
    logic [WIDTH-1:0]    result_q;
    logic [ADDR_W-1:0]   wr_addr_q;

    function automatic logic [WIDTH-1:0] select_result(
        input logic [1:0]         sel,
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   q,
        input logic [WIDTH-1:0]   r
    );
        case (sel)
            2'b00:   return p[WIDTH-1:0];
            2'b01:   return p[2*WIDTH-1:WIDTH];
            2'b10:   return q;
            default: return r;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (cnt == CNT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One iteration of each algorithm; both run in lockstep and op picks the answer.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
        prod_next = {mul_sum, prod[WIDTH-1:1]};

        // The partial remainder is WIDTH+1 bits only after the shift; it is always < divisor afterwards.
        div_shift = {1'b0, rem} << 1 | {{WIDTH{1'b0}}, quot[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, opb}) : div_shift[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            opa       <= '0;
            opb       <= '0;
            rd_q      <= '0;
            cnt       <= '0;
            prod      <= '0;
            rem       <= '0;
            quot      <= '0;
            result_q  <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q <= (next_state != IDLE);
            done_q <= (next_state == DONE);
            case (state)
                IDLE: if (bus.start) begin
                    op_q <= bus.op;
                    opa  <= bus.a;
                    opb  <= bus.b;
                    rd_q <= bus.rd_in;
                    cnt  <= CNT_W'(WIDTH);
                    prod <= {{WIDTH{1'b0}}, bus.b};
                    rem  <= '0;
                    quot <= bus.a;
                end
                RUN: begin
                    cnt  <= cnt - CNT_W'(1);
                    prod <= prod_next;
                    rem  <= rem_next;
                    quot <= quot_next;
                    if (cnt == CNT_W'(1)) begin
                        result_q  <= select_result(op_q, prod_next, quot_next, rem_next);
                        wr_addr_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_en   = done_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.result  = result_q;
endmodule
